// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Segment pattern type and active-low digit patterns (g..a)
//                shared by the 7-segment decoder and its pattern ROM.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    typedef logic [6:0] seg_t;

    // Bit order is {g,f,e,d,c,b,a}; a 0 lights the segment.
    localparam seg_t SEG_OFF = 7'b1111111;

    localparam seg_t SEG_0 = 7'b1000000;
    localparam seg_t SEG_1 = 7'b1111001;
    localparam seg_t SEG_2 = 7'b0100100;
    localparam seg_t SEG_3 = 7'b0110000;
    localparam seg_t SEG_4 = 7'b0011001;
    localparam seg_t SEG_5 = 7'b0010010;
    localparam seg_t SEG_6 = 7'b0000010;
    localparam seg_t SEG_7 = 7'b1111000;
    localparam seg_t SEG_8 = 7'b0000000;
    localparam seg_t SEG_9 = 7'b0010000;
    localparam seg_t SEG_A = 7'b0001000;
    localparam seg_t SEG_B = 7'b0000011;
    localparam seg_t SEG_C = 7'b1000110;
    localparam seg_t SEG_D = 7'b0100001;
    localparam seg_t SEG_E = 7'b0000110;
    localparam seg_t SEG_F = 7'b0001110;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_rom.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_rom
//  Description : Combinational hex nibble to raw active-low segment pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_rom
    import seg7_pkg::*;
(
    input  logic [3:0] i_number,
    output seg_t       o_pattern
);

    always_comb begin
        o_pattern = SEG_OFF;
        case (i_number)
            4'h0:    o_pattern = SEG_0;
            4'h1:    o_pattern = SEG_1;
            4'h2:    o_pattern = SEG_2;
            4'h3:    o_pattern = SEG_3;
            4'h4:    o_pattern = SEG_4;
            4'h5:    o_pattern = SEG_5;
            4'h6:    o_pattern = SEG_6;
            4'h7:    o_pattern = SEG_7;
            4'h8:    o_pattern = SEG_8;
            4'h9:    o_pattern = SEG_9;
            4'hA:    o_pattern = SEG_A;
            4'hB:    o_pattern = SEG_B;
            4'hC:    o_pattern = SEG_C;
            4'hD:    o_pattern = SEG_D;
            4'hE:    o_pattern = SEG_E;
            4'hF:    o_pattern = SEG_F;
            // Unknown codes (X/Z in simulation) leave the digit dark.
            default: o_pattern = SEG_OFF;
        endcase
    end

endmodule : seg7_rom
`default_nettype wire

// File: rtl/seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decoder
//  Description : Registered hex to 7-segment cathode driver (1 cycle latency).
//                Define SEG7_ACTIVE_HIGH_EN for active-high segment drive.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       blank,
    input  logic [3:0] number,
    output logic [6:0] cathode
);

`ifdef SEG7_ACTIVE_HIGH_EN
    localparam seg_t c_dark = ~SEG_OFF;
`else
    localparam seg_t c_dark = SEG_OFF;
`endif

    seg_t w_raw;
    seg_t w_gated;
    seg_t w_drive;
    seg_t r_cathode;

    seg7_rom u_rom (
        .i_number  (number),
        .o_pattern (w_raw)
    );

    assign w_gated = blank ? SEG_OFF : w_raw;

    // Polarity is resolved before the register so latency is the same in both builds.
`ifdef SEG7_ACTIVE_HIGH_EN
    assign w_drive = ~w_gated;
`else
    assign w_drive = w_gated;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cathode <= c_dark;
        end else begin
            r_cathode <= w_drive;
        end
    end

    assign cathode = r_cathode;

endmodule : seg7_decoder
`default_nettype wire

// File: tb/tb_seg7_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_decoder
//  Description : Scoreboard bench for seg7_decoder against a segment-letter model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_decoder;

    typedef struct {
        logic       rst;
        logic       blk;
        logic [3:0] num;
        logic [6:0] exp;
    } txn_t;

    logic       clock;
    logic       reset;
    logic       blank;
    logic [3:0] number;
    logic [6:0] cathode;

    txn_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    seg7_decoder dut (
        .clock   (clock),
        .reset   (reset),
        .blank   (blank),
        .number  (number),
        .cathode (cathode)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Which segments a hex glyph lights, written as segment letters.
    function automatic string glyph(input logic [3:0] n);
        case (n)
            4'h0: return "abcdef";
            4'h1: return "bc";
            4'h2: return "abdeg";
            4'h3: return "abcdg";
            4'h4: return "bcfg";
            4'h5: return "acdfg";
            4'h6: return "acdefg";
            4'h7: return "abc";
            4'h8: return "abcdefg";
            4'h9: return "abcdfg";
            4'hA: return "abcefg";
            4'hB: return "cdefg";
            4'hC: return "adef";
            4'hD: return "bcdeg";
            4'hE: return "adefg";
            default: return "aefg";
        endcase
    endfunction

    function automatic logic [6:0] model(input logic r, input logic b, input logic [3:0] n);
        logic [6:0] lit;
        string      s;
        lit = 7'd0;
        if (!r && !b) begin
            s = glyph(n);
            for (int i = 0; i < s.len(); i++) lit[s.getc(i) - 8'd97] = 1'b1;
        end
`ifdef SEG7_ACTIVE_HIGH_EN
        return lit;
`else
        return ~lit;
`endif
    endfunction

    task automatic step(input logic r, input logic b, input logic [3:0] n);
        txn_t t;
        @(negedge clock);
        reset  = r;
        blank  = b;
        number = n;
        t.rst = r;
        t.blk = b;
        t.num = n;
        t.exp = model(r, b, n);
        q.push_back(t);
    endtask

    // Monitor: one result per rising edge for each issued stimulus.
    initial begin
        txn_t t;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                t = q.pop_front();
                n_cmp++;
                if (cathode !== t.exp) begin
                    n_bad++;
                    $display("FAIL cathode (rst=%0b blank=%0b num=%h): got %b expected %b",
                             t.rst, t.blk, t.num, cathode, t.exp);
                end
            end
        end
    end

    initial begin
        reset  = 1'b1;
        blank  = 1'b0;
        number = 4'h8;

        // Reset held two cycles, then release with 8 on the bus.
        step(1'b1, 1'b0, 4'h8);
        step(1'b1, 1'b0, 4'h8);
        step(1'b0, 1'b0, 4'h8);
        step(1'b0, 1'b0, 4'h8);

        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, 4'(i));

        step(1'b0, 1'b1, 4'h3);
        step(1'b0, 1'b0, 4'h3);

        step(1'b1, 1'b0, 4'h1);
        step(1'b0, 1'b0, 4'h1);

        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, (i % 2 == 0) ? 4'h5 : 4'hC);

        step(1'b1, 1'b1, 4'h0);
        step(1'b0, 1'b0, 4'h0);

        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0),
                 4'($urandom_range(0, 15)));
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clock);
        #3;
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_seg7_decoder
`default_nettype wire
